// File: rtl/ps2_packet_framer.sv
// PS/2 packet framer: hunts for a sync-marked start byte and assembles PKT_BYTES-byte packets
// into a one-entry valid/ready buffer. Define PS2_FRAMER_STATS_EN to add drop/resync/timeout counters.
module ps2_packet_framer #(
    parameter int PKT_BYTES   = 3,
    parameter int SYNC_BIT    = 3,
    parameter int SYNC_VAL    = 1,
    parameter int TIMEOUT_CYC = 0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic [8*PKT_BYTES-1:0] pkt_data,
    output logic                   pkt_valid,
    input  logic                   pkt_ready,
    output logic                   overflow,
    output logic                   timeout_err
`ifdef PS2_FRAMER_STATS_EN
    ,
    output logic [15:0]            drop_cnt,
    output logic [15:0]            resync_cnt,
    output logic [15:0]            timeout_cnt
`endif
);

    localparam int IDX_W = $clog2(PKT_BYTES);
    localparam int GAP_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_BYTES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = (TIMEOUT_CYC > 0) ? GAP_W'(TIMEOUT_CYC - 1) : '0;
    localparam logic [GAP_W-1:0] GAP_MAX  = '1;
    localparam logic SYNC_LVL = (SYNC_VAL != 0);

    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t                 state_reg, state_next;
    logic [IDX_W-1:0]       idx_reg, idx_next;
    logic [GAP_W-1:0]       gap_reg, gap_next;
    logic [8*PKT_BYTES-1:0] asm_reg, asm_next;
    logic [8*PKT_BYTES-1:0] pkt_data_reg, pkt_data_next;
    logic                   pkt_valid_reg, pkt_valid_next;
    logic                   overflow_reg, timeout_err_reg;

    logic is_sync;
    logic store;
    logic complete;
    logic load;
    logic drop_evt;
    logic timeout_evt;

    assign is_sync = (in_data[SYNC_BIT] == SYNC_LVL);

    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        gap_next    = gap_reg;
        store       = 1'b0;
        complete    = 1'b0;
        timeout_evt = 1'b0;
        case (state_reg)
            HUNT: begin
                gap_next = '0;
                if (in_valid && is_sync) begin
                    store      = 1'b1;
                    idx_next   = IDX_W'(1);
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                if (in_valid) begin
                    store    = 1'b1;
                    gap_next = '0;
                    if (idx_reg == LAST_IDX) begin
                        complete   = 1'b1;
                        idx_next   = '0;
                        state_next = HUNT;
                    end else begin
                        idx_next = idx_reg + IDX_W'(1);
                    end
                end else if (TIMEOUT_CYC > 0) begin
                    if (gap_reg == GAP_LAST) begin
                        timeout_evt = 1'b1;
                        idx_next    = '0;
                        gap_next    = '0;
                        state_next  = HUNT;
                    end else if (gap_reg != GAP_MAX) begin
                        gap_next = gap_reg + GAP_W'(1);
                    end
                end
            end
            default: begin
                state_next = HUNT;
                idx_next   = '0;
                gap_next   = '0;
            end
        endcase
    end

    // Byte lane gi holds packet byte gi; byte 0 sits in the MSBs.
    genvar gi;
    generate
        for (gi = 0; gi < PKT_BYTES; gi++) begin : g_lane
            always_comb begin
                asm_next[8*(PKT_BYTES-1-gi) +: 8] = asm_reg[8*(PKT_BYTES-1-gi) +: 8];
                if (store && (idx_reg == IDX_W'(gi)))
                    asm_next[8*(PKT_BYTES-1-gi) +: 8] = in_data;
            end
        end
    endgenerate

    // A completed packet goes into the buffer only if the buffer is free or draining this cycle.
    assign load     = complete && (!pkt_valid_reg || pkt_ready);
    assign drop_evt = complete && pkt_valid_reg && !pkt_ready;

    always_comb begin
        pkt_data_next  = pkt_data_reg;
        pkt_valid_next = pkt_valid_reg && !pkt_ready;
        if (load) begin
            pkt_data_next  = asm_next;
            pkt_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= HUNT;
            idx_reg         <= '0;
            gap_reg         <= '0;
            asm_reg         <= '0;
            pkt_data_reg    <= '0;
            pkt_valid_reg   <= 1'b0;
            overflow_reg    <= 1'b0;
            timeout_err_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            idx_reg         <= idx_next;
            gap_reg         <= gap_next;
            asm_reg         <= asm_next;
            pkt_data_reg    <= pkt_data_next;
            pkt_valid_reg   <= pkt_valid_next;
            overflow_reg    <= drop_evt;
            timeout_err_reg <= timeout_evt;
        end
    end

    assign pkt_data    = pkt_data_reg;
    assign pkt_valid   = pkt_valid_reg;
    assign overflow    = overflow_reg;
    assign timeout_err = timeout_err_reg;

`ifdef PS2_FRAMER_STATS_EN
    logic        resync_evt;
    logic [15:0] drop_cnt_reg, resync_cnt_reg, timeout_cnt_reg;

    assign resync_evt = (state_reg == HUNT) && in_valid && !is_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt_reg    <= '0;
            resync_cnt_reg  <= '0;
            timeout_cnt_reg <= '0;
        end else begin
            if (drop_evt && (drop_cnt_reg != 16'hFFFF))
                drop_cnt_reg <= drop_cnt_reg + 16'd1;
            if (resync_evt && (resync_cnt_reg != 16'hFFFF))
                resync_cnt_reg <= resync_cnt_reg + 16'd1;
            if (timeout_evt && (timeout_cnt_reg != 16'hFFFF))
                timeout_cnt_reg <= timeout_cnt_reg + 16'd1;
        end
    end

    assign drop_cnt    = drop_cnt_reg;
    assign resync_cnt  = resync_cnt_reg;
    assign timeout_cnt = timeout_cnt_reg;
`endif

endmodule

// File: tb/tb_ps2_packet_framer.sv
// Scoreboard bench for ps2_packet_framer (3-byte packets, 4-cycle timeout): directed cases then random traffic.
module tb_ps2_packet_framer;

    localparam int N   = 3;
    localparam int SB  = 3;
    localparam int SV  = 1;
    localparam int TMO = 4;

    logic             clk;
    logic             reset_n;
    logic [7:0]       in_data;
    logic             in_valid;
    logic [8*N-1:0]   pkt_data;
    logic             pkt_valid;
    logic             pkt_ready;
    logic             overflow;
    logic             timeout_err;
`ifdef PS2_FRAMER_STATS_EN
    logic [15:0]      drop_cnt, resync_cnt, timeout_cnt;
`endif

    ps2_packet_framer #(
        .PKT_BYTES  (N),
        .SYNC_BIT   (SB),
        .SYNC_VAL   (SV),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .pkt_data   (pkt_data),
        .pkt_valid  (pkt_valid),
        .pkt_ready  (pkt_ready),
        .overflow   (overflow),
        .timeout_err(timeout_err)
`ifdef PS2_FRAMER_STATS_EN
        ,
        .drop_cnt   (drop_cnt),
        .resync_cnt (resync_cnt),
        .timeout_cnt(timeout_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        int             tag;
        logic           valid;
        logic [8*N-1:0] data;
        logic           ovf;
        logic           to;
    } rec_t;

    rec_t           recq[$];
    logic [8*N-1:0] pktq[$];

    int nvec = 0;
    int nerr = 0;

    // Reference model: bytes of the packet in progress, idle gap, one-entry buffer.
    logic [7:0]     part[$];
    int             m_gap = 0;
    logic           m_full = 1'b0;
    logic [8*N-1:0] m_data = '0;
    int             m_drops = 0, m_resyncs = 0, m_timeouts = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        part.delete();
        m_gap  = 0;
        m_full = 1'b0;
        m_data = '0;
    endtask

    // Computes the expected outputs after the coming clock edge for the given inputs.
    task automatic model_step(input logic v, input logic [7:0] d, input logic r);
        rec_t           rc;
        logic           ovf = 1'b0;
        logic           to  = 1'b0;
        logic           was_full = m_full;
        logic [8*N-1:0] pk;
        m_full = m_full && !r;
        if (part.size() == 0) begin
            if (v && (d[SB] == SV[0])) part.push_back(d);
            else if (v) m_resyncs++;
        end else if (v) begin
            part.push_back(d);
            m_gap = 0;
            if (part.size() == N) begin
                pk = '0;
                foreach (part[i]) pk = (pk << 8) | (8*N)'(part[i]);
                if (!was_full || r) begin
                    m_data = pk;
                    m_full = 1'b1;
                    pktq.push_back(pk);
                end else begin
                    ovf = 1'b1;
                    m_drops++;
                end
                part.delete();
            end
        end else begin
            m_gap++;
            if (m_gap == TMO) begin
                to = 1'b1;
                m_timeouts++;
                part.delete();
                m_gap = 0;
            end
        end
        rc.tag = cyc + 1; rc.valid = m_full; rc.data = m_data; rc.ovf = ovf; rc.to = to;
        recq.push_back(rc);
    endtask

    // Called at posedge+1: drives inputs for the next edge, then waits until posedge+1 again.
    task automatic drive(input logic v, input logic [7:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        pkt_ready = r;
        model_step(v, d, r);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, r);
    endtask

    task automatic check_zero_outputs(input string tagname);
        check({tagname, "_pkt_data"},    64'(pkt_data),    64'h0);
        check({tagname, "_pkt_valid"},   64'(pkt_valid),   64'h0);
        check({tagname, "_overflow"},    64'(overflow),    64'h0);
        check({tagname, "_timeout_err"}, 64'(timeout_err), 64'h0);
    endtask

    // Monitor: pops the per-cycle expectation and checks handshakes against the packet queue.
    always @(negedge clk) begin
        if (reset_n) begin
            while (recq.size() > 0 && recq[0].tag < cyc) void'(recq.pop_front());
            if (recq.size() > 0 && recq[0].tag == cyc) begin
                rec_t rc;
                rc = recq.pop_front();
                check("pkt_valid", 64'(pkt_valid), 64'(rc.valid));
                check("overflow", 64'(overflow), 64'(rc.ovf));
                check("timeout_err", 64'(timeout_err), 64'(rc.to));
                if (rc.valid) check("pkt_data", 64'(pkt_data), 64'(rc.data));
            end
            if (pkt_valid && pkt_ready) begin
                if (pktq.size() == 0) begin
                    check("unexpected_handshake", 64'(pkt_data), 64'hDEAD_0000_0000_0000);
                end else begin
                    check("handshake_data", 64'(pkt_data), 64'(pktq.pop_front()));
                end
            end
        end
    end

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        pkt_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        reset_n = 1'b1;

        // Basic packet, then resync past non-sync bytes.
        drive(1, 8'h08, 1); drive(1, 8'hAA, 1); drive(1, 8'hBB, 1); idle(2, 1);
        drive(1, 8'h00, 1); drive(1, 8'hF7, 1);
        drive(1, 8'h18, 1); drive(1, 8'h11, 1); drive(1, 8'h22, 1); idle(1, 1);
        // Back-to-back packets with no dead cycle.
        drive(1, 8'h08, 1); drive(1, 8'h01, 1); drive(1, 8'h02, 1);
        drive(1, 8'h09, 1); drive(1, 8'h04, 1); drive(1, 8'h05, 1); idle(1, 1);
        // Overflow: buffer held full while a second packet completes.
        drive(1, 8'h08, 0); drive(1, 8'h01, 0); drive(1, 8'h02, 0);
        drive(1, 8'h08, 0); drive(1, 8'h03, 0); drive(1, 8'h04, 0);
        idle(2, 0); idle(2, 1);
        // Timeout after four idle cycles, then three idle cycles are tolerated.
        drive(1, 8'h08, 1); drive(1, 8'h01, 1); idle(4, 1);
        drive(1, 8'h09, 1); drive(1, 8'h02, 1); idle(3, 1); drive(1, 8'h03, 1); idle(2, 1);
        // Reset mid-packet with a packet held in the buffer.
        drive(1, 8'h0A, 0); drive(1, 8'h0B, 0); drive(1, 8'h0C, 0);
        drive(1, 8'h08, 0); drive(1, 8'h01, 0);
        reset_n  = 1'b0;
        in_valid = 1'b0;
        #1;
        check_zero_outputs("async_reset");
        recq.delete();
        pktq.delete();
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        drive(1, 8'h0A, 1); drive(1, 8'h0B, 1); drive(1, 8'h0C, 1); idle(2, 1);

        // Random traffic with alternating busy and sparse phases so timeouts and overflows occur.
        for (int i = 0; i < 3000; i++) begin
            logic       v, r;
            logic [7:0] d;
            if (((i / 50) % 2) == 0) v = ($urandom_range(0, 99) < 70);
            else                     v = ($urandom_range(0, 99) < 15);
            d = 8'($urandom);
            r = ($urandom_range(0, 99) < 60);
            drive(v, d, r);
        end
        idle(6, 1);
        @(negedge clk);
        check("pkt_queue_drained", 64'(pktq.size()), 64'h0);
`ifdef PS2_FRAMER_STATS_EN
        check("drop_cnt", 64'(drop_cnt), 64'(m_drops));
        check("resync_cnt", 64'(resync_cnt), 64'(m_resyncs));
        check("timeout_cnt", 64'(timeout_cnt), 64'(m_timeouts));
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
